cpu_ce_gen: RTL and testbench



---
 rtl/clk_gen_pkg.sv | 22 ++
 rtl/ce_div.sv | 25 ++
 rtl/cpu_ce_gen.sv | 108 ++++++++++
 tb/tb_cpu_ce_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// Shared constants for the clock-enable generator: speed encodings, default
// divider ratios and a counter-width helper.
package clk_gen_pkg;

    localparam int SPEED_1X = 0;
    localparam int SPEED_2X = 1;
    localparam int SPEED_4X = 2;

    localparam int DEF_BASE_DIV      = 28;
    localparam int DEF_MAX_MULT      = 4;
    localparam int DEF_F2_OFFSET     = 2;
    localparam int DEF_PERIPH_OFFSET = 4;
    localparam int DEF_VID_DIV       = 6;
    localparam int DEF_VID2X_PHASE   = 3;
    localparam int DEF_PS2_DIV       = 3571;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ce_div.sv
// Free-running mod-N counter with a registered strobe at count 0. The count is
// exported so the parent can decode extra phases from it.
module ce_div
    import clk_gen_pkg::*;
#(
    parameter int N = DEF_VID_DIV,
    localparam int W = cnt_w(N)
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    output logic [W-1:0] cnt,
    output logic         ce
);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else begin
            ce  <= (cnt == '0);
            cnt <= (cnt == W'(N - 1)) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/cpu_ce_gen.sv
// Clock-enable generator for the 8080-family cores: two-phase CPU strobes with
// speed multiplier and pause, plus fixed-rate peripheral, video and PS/2 strobes.
module cpu_ce_gen
    import clk_gen_pkg::*;
#(
    parameter int BASE_DIV      = DEF_BASE_DIV,
    parameter int MAX_MULT      = DEF_MAX_MULT,
    parameter int F2_OFFSET     = DEF_F2_OFFSET,
    parameter int PERIPH_OFFSET = DEF_PERIPH_OFFSET,
    parameter int VID_DIV       = DEF_VID_DIV,
    parameter int VID2X_PHASE   = DEF_VID2X_PHASE,
    parameter int PS2_DIV       = DEF_PS2_DIV
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic [$clog2(MAX_MULT):0]   speed,
    input  logic                        pause,
    output logic                        ce_f1,
    output logic                        ce_f2,
    output logic                        ce_periph,
    output logic                        ce_pix,
    output logic                        ce_pix2x,
    output logic                        ce_ps2,
    output logic [$clog2(MAX_MULT):0]   speed_cur,
    output logic                        paused
);

    localparam int SLOT     = BASE_DIV / MAX_MULT;
    localparam int PW       = cnt_w(SLOT);
    localparam int SW       = cnt_w(MAX_MULT);
    localparam int LOG2_MAX = $clog2(MAX_MULT);
    localparam int SPW      = LOG2_MAX + 1;
    localparam int VW       = cnt_w(VID_DIV);
    localparam int PSW      = cnt_w(PS2_DIV);
    localparam int PER_SLOT  = PERIPH_OFFSET / SLOT;
    localparam int PER_PHASE = PERIPH_OFFSET % SLOT;

    logic [PW-1:0]  phase;
    logic [SW-1:0]  slot;
    logic [SW-1:0]  slot_mask;
    logic [SPW-1:0] speed_clamped;
    logic           phase0, phase_last, slot_last, slot_active;
    logic           f1_now, arm_next, armed, fresh;
    logic [VW-1:0]  vid_cnt;
    logic [PSW-1:0] ps2_cnt;
    logic           unused_ps2_cnt;

    assign phase0        = (phase == '0);
    assign phase_last    = (phase == PW'(SLOT - 1));
    assign slot_last     = (slot == SW'(MAX_MULT - 1));
    assign speed_clamped = (speed > SPW'(LOG2_MAX)) ? SPW'(LOG2_MAX) : speed;
    // MAX_MULT is a power of two, so the slot modulo reduces to a mask.
    assign slot_mask     = SW'((MAX_MULT >> speed_cur) - 1);
    assign slot_active   = ((slot & slot_mask) == '0);
    assign f1_now        = phase0 && slot_active && !pause;
    // The arm bit carries "ce_f1 fired in this slot" forward to the ce_f2 phase.
    assign arm_next      = phase0 ? f1_now : armed;
    assign unused_ps2_cnt = ^ps2_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= '0;
            slot      <= '0;
            speed_cur <= '0;
            paused    <= 1'b0;
            armed     <= 1'b0;
            fresh     <= 1'b1;
            ce_f1     <= 1'b0;
            ce_f2     <= 1'b0;
            ce_periph <= 1'b0;
            ce_pix2x  <= 1'b0;
        end else begin
            fresh <= 1'b0;
            if (phase_last) begin
                phase <= '0;
                slot  <= slot_last ? '0 : slot + SW'(1);
            end else begin
                phase <= phase + PW'(1);
            end
            // Slot 0 is active at every speed, so adopting the requested speed on
            // the first cycle out of reset never splits a base period.
            if ((phase_last && slot_last) || fresh)
                speed_cur <= speed_clamped;
            if (phase0 && slot_active)
                paused <= pause;
            armed     <= arm_next;
            ce_f1     <= f1_now;
            ce_f2     <= (phase == PW'(F2_OFFSET)) && arm_next;
            ce_periph <= (slot == SW'(PER_SLOT)) && (phase == PW'(PER_PHASE));
            ce_pix2x  <= (vid_cnt == '0) || (vid_cnt == VW'(VID2X_PHASE));
        end
    end

    ce_div #(.N(VID_DIV)) u_vid_div (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .cnt     (vid_cnt),
        .ce      (ce_pix)
    );

    ce_div #(.N(PS2_DIV)) u_ps2_div (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .cnt     (ps2_cnt),
        .ce      (ce_ps2)
    );

endmodule

// File: tb/tb_cpu_ce_gen.sv
// Directed bench for cpu_ce_gen: strobe positions are captured as per-cycle
// bitmasks (bit k = fired in cycle k after reset release) and compared to hand values.
module tb_cpu_ce_gen;
    import clk_gen_pkg::*;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] speed   = '0;
    logic       pause   = 1'b0;
    logic       ce_f1, ce_f2, ce_periph, ce_pix, ce_pix2x, ce_ps2, paused;
    logic [2:0] speed_cur;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [63:0] f1_m, f2_m, per_m, pix_m, pix2_m, ps2_m;
    logic [2:0]  sc_a [0:63];
    logic        pz_a [0:63];

    cpu_ce_gen dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .speed     (speed),
        .pause     (pause),
        .ce_f1     (ce_f1),
        .ce_f2     (ce_f2),
        .ce_periph (ce_periph),
        .ce_pix    (ce_pix),
        .ce_pix2x  (ce_pix2x),
        .ce_ps2    (ce_ps2),
        .speed_cur (speed_cur),
        .paused    (paused)
    );

    always #10 clk_sys = ~clk_sys;

    // Mask with a bit set for each listed cycle (negative entries ignored).
    function automatic logic [63:0] m(input int a, input int b = -1, input int c = -1,
                                      input int d = -1);
        logic [63:0] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        if (c >= 0) r[c] = 1'b1;
        if (d >= 0) r[d] = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    // Runs n cycles after release, recording strobes; inputs change after the
    // named cycle has been observed.
    task automatic capture(input int n, input int spd_at, input logic [2:0] spd_val,
                           input int p_on, input int p_off);
        f1_m = '0; f2_m = '0; per_m = '0; pix_m = '0; pix2_m = '0; ps2_m = '0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (ce_f1)     f1_m[cyc]   = 1'b1;
            if (ce_f2)     f2_m[cyc]   = 1'b1;
            if (ce_periph) per_m[cyc]  = 1'b1;
            if (ce_pix)    pix_m[cyc]  = 1'b1;
            if (ce_pix2x)  pix2_m[cyc] = 1'b1;
            if (ce_ps2)    ps2_m[cyc]  = 1'b1;
            sc_a[cyc] = speed_cur;
            pz_a[cyc] = paused;
            if (cyc == spd_at) speed = spd_val;
            if (cyc == p_on)   pause = 1'b1;
            if (cyc == p_off)  pause = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        speed = 3'd2;
        pause = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        outs = {ce_f1, ce_f2, ce_periph, ce_pix, ce_pix2x, ce_ps2, paused, |speed_cur};
        checks++;
        if (outs !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", outs, 8'h00);
        end
        pause = 1'b0;
    endtask

    task automatic test_speed1x();
        logic [63:0] e;
        speed = 3'd0;
        do_reset();
        capture(63, -1, 3'd0, -1, -1);
        e = m(1, 29, 57);
        checks++;
        if (f1_m !== e) begin failures++; $display("FAIL f1_1x got=%h exp=%h", f1_m, e); end
        e = m(3, 31, 59);
        checks++;
        if (f2_m !== e) begin failures++; $display("FAIL f2_1x got=%h exp=%h", f2_m, e); end
        e = m(5, 33, 61);
        checks++;
        if (per_m !== e) begin failures++; $display("FAIL periph_1x got=%h exp=%h", per_m, e); end
        e = '0;
        for (int k = 1; k < 64; k += 6) e[k] = 1'b1;
        checks++;
        if (pix_m !== e) begin failures++; $display("FAIL pix got=%h exp=%h", pix_m, e); end
        e = '0;
        for (int k = 1; k < 64; k += 3) e[k] = 1'b1;
        checks++;
        if (pix2_m !== e) begin failures++; $display("FAIL pix2x got=%h exp=%h", pix2_m, e); end
        e = m(1);
        checks++;
        if (ps2_m !== e) begin failures++; $display("FAIL ps2_first got=%h exp=%h", ps2_m, e); end
        checks++;
        if (sc_a[63] !== 3'(SPEED_1X)) begin
            failures++;
            $display("FAIL speed_cur_1x got=%0d exp=%0d", sc_a[63], SPEED_1X);
        end
        while (cyc < 4000 && ce_ps2 !== 1'b1) step();
        checks++;
        if (cyc != 3572) begin
            failures++;
            $display("FAIL ps2_second got_cycle=%0d exp_cycle=%0d", cyc, 3572);
        end
    endtask

    task automatic test_speed4x(input logic [2:0] spd, input string tag);
        logic [63:0] e1, e2;
        speed = spd;
        do_reset();
        capture(63, -1, spd, -1, -1);
        e1 = '0;
        e2 = '0;
        for (int k = 1; k < 64; k += 7) begin
            e1[k] = 1'b1;
            if (k + 2 < 64) e2[k + 2] = 1'b1;
        end
        checks++;
        if (f1_m !== e1) begin failures++; $display("FAIL f1_%s got=%h exp=%h", tag, f1_m, e1); end
        checks++;
        if (f2_m !== e2) begin failures++; $display("FAIL f2_%s got=%h exp=%h", tag, f2_m, e2); end
        e1 = m(5, 33, 61);
        checks++;
        if (per_m !== e1) begin failures++; $display("FAIL periph_%s got=%h exp=%h", tag, per_m, e1); end
        checks++;
        if (sc_a[40] !== 3'(SPEED_4X)) begin
            failures++;
            $display("FAIL speed_cur_%s got=%0d exp=%0d", tag, sc_a[40], SPEED_4X);
        end
    endtask

    task automatic test_speed_change();
        logic [63:0] e;
        speed = 3'd0;
        do_reset();
        capture(63, 9, 3'd1, -1, -1);
        e = m(1, 29, 43, 57);
        checks++;
        if (f1_m !== e) begin failures++; $display("FAIL f1_change got=%h exp=%h", f1_m, e); end
        e = m(3, 31, 45, 59);
        checks++;
        if (f2_m !== e) begin failures++; $display("FAIL f2_change got=%h exp=%h", f2_m, e); end
        checks++;
        if (sc_a[27] !== 3'd0) begin
            failures++;
            $display("FAIL speed_cur_before got=%0d exp=%0d", sc_a[27], 0);
        end
        checks++;
        if (sc_a[28] !== 3'(SPEED_2X)) begin
            failures++;
            $display("FAIL speed_cur_after got=%0d exp=%0d", sc_a[28], SPEED_2X);
        end
    endtask

    task automatic test_pause();
        logic [63:0] e;
        logic [2:0]  pz;
        speed = 3'd0;
        pause = 1'b0;
        do_reset();
        capture(63, -1, 3'd0, 1, 40);
        e = m(1, 57);
        checks++;
        if (f1_m !== e) begin failures++; $display("FAIL f1_pause got=%h exp=%h", f1_m, e); end
        e = m(3, 59);
        checks++;
        if (f2_m !== e) begin failures++; $display("FAIL f2_pause got=%h exp=%h", f2_m, e); end
        e = m(5, 33, 61);
        checks++;
        if (per_m !== e) begin failures++; $display("FAIL periph_pause got=%h exp=%h", per_m, e); end
        pz = {pz_a[28], pz_a[45], pz_a[57]};
        checks++;
        if (pz !== 3'b010) begin
            failures++;
            $display("FAIL paused_flag got=%b exp=%b", pz, 3'b010);
        end
        pause = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [63:0] e;
        logic        f2_seen;
        logic [7:0]  outs;
        speed = 3'd0;
        do_reset();
        step();
        checks++;
        if (ce_f1 !== 1'b1) begin failures++; $display("FAIL f1_pre_pulse got=%b exp=%b", ce_f1, 1'b1); end
        step();
        reset_n = 1'b0;
        #1;
        outs = {ce_f1, ce_f2, ce_periph, ce_pix, ce_pix2x, ce_ps2, paused, |speed_cur};
        checks++;
        if (outs !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b exp=%b", outs, 8'h00);
        end
        f2_seen = 1'b0;
        repeat (4) begin
            @(posedge clk_sys);
            #1;
            if (ce_f2) f2_seen = 1'b1;
        end
        checks++;
        if (f2_seen !== 1'b0) begin failures++; $display("FAIL orphan_f2 got=%b exp=%b", f2_seen, 1'b0); end
        @(negedge clk_sys);
        reset_n = 1'b1;
        cyc = 0;
        capture(63, -1, 3'd0, -1, -1);
        e = m(1, 29, 57);
        checks++;
        if (f1_m !== e) begin failures++; $display("FAIL f1_restart got=%h exp=%h", f1_m, e); end
        e = m(3, 31, 59);
        checks++;
        if (f2_m !== e) begin failures++; $display("FAIL f2_restart got=%h exp=%h", f2_m, e); end
    endtask

    initial begin
        test_reset();
        test_speed1x();
        test_speed4x(3'd2, "4x");
        test_speed_change();
        test_pause();
        test_reset_mid();
        test_speed4x(3'd7, "clamp");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
